// File: rtl/puf_pkg.sv
// Shared types, constants and helpers for the arbiter-PUF sequencer.
package puf_pkg;

  // Width and feedback taps of the challenge-expansion LFSR
  localparam int LFSR_W = 32;
  localparam int TAP_0  = 31;
  localparam int TAP_1  = 21;
  localparam int TAP_2  = 1;
  localparam int TAP_3  = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARB_RST = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_SAMPLE  = 3'd3,
    ST_NEXT    = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // One Fibonacci step: shift left, feedback enters at bit 0
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    logic fb;
    fb = l[TAP_0] ^ l[TAP_1] ^ l[TAP_2] ^ l[TAP_3];
    return {l[LFSR_W-2:0], fb};
  endfunction

  // Ceiling log2, never below 1 so counters always have at least one bit
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/puf_sync2.sv
// Two-flop synchroniser for the asynchronous arbiter output.
module puf_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Capture the asynchronous input, then resolve metastability in a second stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/puf_arbiter_ctrl.sv
// Arbiter-PUF sequencer: expands a seed into per-bit challenges, times the
// arbiter reset / launch edges, and majority-votes each response bit.
module puf_arbiter_ctrl
  import puf_pkg::*;
#(
  parameter int STAGES    = 64,
  parameter int RESP_BITS = 16,
  parameter int VOTES     = 5,
  parameter int SETTLE    = 4,
  parameter int RESET_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [31:0]          seed_i,
  output logic [STAGES-1:0]    chal_o,
  output logic                 launch_o,
  output logic                 arb_rst_o,
  input  logic                 arb_i,
  output logic                 busy_o,
  output logic [RESP_BITS-1:0] resp_o,
  output logic [RESP_BITS-1:0] unstable_o,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i
);

  localparam int VOTE_W    = clog2(VOTES + 1);
  localparam int BIT_W     = clog2(RESP_BITS + 1);
  localparam int PHASE_MAX = (RESET_CYC > SETTLE) ? RESET_CYC : SETTLE;
  localparam int PHASE_W   = clog2(PHASE_MAX + 1);

  state_t                 r_state;
  logic [LFSR_W-1:0]      r_lfsr;
  logic [RESP_BITS-1:0]   r_resp;
  logic [RESP_BITS-1:0]   r_unstable;
  logic                   r_resp_valid;
  logic                   r_busy;
  logic                   r_launch;
  logic                   r_arb_rst;
  logic [VOTE_W-1:0]      r_vote;
  logic [VOTE_W-1:0]      r_ones;
  logic [BIT_W-1:0]       r_bit;
  logic [PHASE_W-1:0]     r_phase;

  logic                   w_arb_s;
  logic [VOTE_W-1:0]      w_vote_inc;
  logic                   w_major;
  logic                   w_split;
  logic [RESP_BITS-1:0]   w_resp_next;
  logic [RESP_BITS-1:0]   w_unst_next;

  puf_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (arb_i),
    .o_q (w_arb_s)
  );

  // Challenge repeats the 32-bit LFSR across the whole chain
  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_chal
      assign chal_o[g] = r_lfsr[g % LFSR_W];
    end
  endgenerate

  assign w_vote_inc = r_vote + VOTE_W'(1);
  assign w_major    = (r_ones > VOTE_W'(VOTES / 2));
  assign w_split    = (r_ones != VOTE_W'(0)) && (r_ones != VOTE_W'(VOTES));

  // Merge the voted result of the current bit into the response vectors
  always_comb begin
    w_resp_next = r_resp;
    w_unst_next = r_unstable;
    for (int i = 0; i < RESP_BITS; i++) begin
      if (r_bit == BIT_W'(i)) begin
        w_resp_next[i] = w_major;
        w_unst_next[i] = w_split;
      end else begin
        w_resp_next[i] = r_resp[i];
        w_unst_next[i] = r_unstable[i];
      end
    end
  end

  // Sequencer FSM with registered chain controls and handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_lfsr       <= '0;
      r_resp       <= '0;
      r_unstable   <= '0;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_launch     <= 1'b0;
      r_arb_rst    <= 1'b1;
      r_vote       <= '0;
      r_ones       <= '0;
      r_bit        <= '0;
      r_phase      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_arb_rst <= 1'b1;
          r_launch  <= 1'b0;
          if (start_i) begin
            r_lfsr     <= (seed_i == 32'h0) ? 32'h1 : seed_i;
            r_resp     <= '0;
            r_unstable <= '0;
            r_vote     <= '0;
            r_ones     <= '0;
            r_bit      <= '0;
            r_phase    <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_ARB_RST;
          end
        end
        ST_ARB_RST: begin
          if (r_phase == PHASE_W'(RESET_CYC - 1)) begin
            r_phase   <= '0;
            r_arb_rst <= 1'b0;
            r_launch  <= 1'b1;
            r_state   <= ST_LAUNCH;
          end else begin
            r_phase <= r_phase + PHASE_W'(1);
          end
        end
        ST_LAUNCH: begin
          if (r_phase == PHASE_W'(SETTLE - 1)) begin
            r_phase <= '0;
            r_state <= ST_SAMPLE;
          end else begin
            r_phase <= r_phase + PHASE_W'(1);
          end
        end
        ST_SAMPLE: begin
          // Arbiter result has had SETTLE cycles to cross the synchroniser
          r_ones    <= r_ones + VOTE_W'(w_arb_s);
          r_vote    <= w_vote_inc;
          r_launch  <= 1'b0;
          r_arb_rst <= 1'b1;
          if (w_vote_inc == VOTE_W'(VOTES)) begin
            r_state <= ST_NEXT;
          end else begin
            r_state <= ST_ARB_RST;
          end
        end
        ST_NEXT: begin
          r_resp     <= w_resp_next;
          r_unstable <= w_unst_next;
          r_ones     <= '0;
          r_vote     <= '0;
          r_bit      <= r_bit + BIT_W'(1);
          r_lfsr     <= lfsr_next(r_lfsr);
          if (r_bit == BIT_W'(RESP_BITS - 1)) begin
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_ARB_RST;
          end
        end
        ST_DONE: begin
          r_arb_rst <= 1'b1;
          r_launch  <= 1'b0;
          // Valid rises one cycle after entry; only a visible response can be consumed
          if (!r_resp_valid) begin
            r_resp_valid <= 1'b1;
          end else if (resp_ready_i) begin
            r_resp_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_launch     <= 1'b0;
          r_arb_rst    <= 1'b1;
        end
      endcase
    end
  end

  assign launch_o     = r_launch;
  assign arb_rst_o    = r_arb_rst;
  assign busy_o       = r_busy;
  assign resp_o       = r_resp;
  assign unstable_o   = r_unstable;
  assign resp_valid_o = r_resp_valid;

endmodule

// File: doc/puf_arbiter_ctrl.md
Name: puf_arbiter_ctrl

Overview:
Sequencer for an N-stage arbiter PUF delay chain with majority voting. It expands a 32-bit seed into a per-bit STAGES-wide challenge and drives the chain's launch edge and arbiter reset. For each response bit it samples the arbiter VOTES times, takes the majority, and flags bits where the votes disagree. It sits beside puf_arbiter_chain at board top level; the chain's arbiter output feeds arb_i, and the response/handshake ports go to the host/LED logic.

Parameters:
STAGES, 64, chain length and chal_o width (any value >= 1)
RESP_BITS, 16, response bits per evaluation (1..64)
VOTES, 5, evaluations per bit; must be odd, >= 1
SETTLE, 4, cycles launch_o is held high before sampling; must be >= 3 to cover the synchroniser
RESET_CYC, 4, cycles arb_rst_o is held high before each launch (>= 1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start_i  in  1  request an evaluation; accepted only in IDLE
seed_i  in  32  challenge seed, captured when start is accepted
chal_o  out  STAGES  challenge to the chain; chal_o[i] = lfsr[i mod 32]
launch_o  out  1  rising edge drives both chain inputs
arb_rst_o  out  1  clears the arbiter flip-flop in the chain
arb_i  in  1  asynchronous arbiter output, synchronised internally
busy_o  out  1  high from the cycle after accept through the last NEXT cycle
resp_o  out  RESP_BITS  response; bit 0 is the first bit evaluated
unstable_o  out  RESP_BITS  per-bit flag: votes not unanimous
resp_valid_o  out  1  response valid; held until consumed
resp_ready_i  in  1  consumer accepts the response

Behaviour:
- Reset (async assert, sync release): state=IDLE, lfsr=0, resp_o=0, unstable_o=0, resp_valid_o=0, busy_o=0, launch_o=0, arb_rst_o=1, vote/bit/phase counters=0, synchroniser flops=0.
- Synchroniser: 2-flop, always clocking; arb_s is the second flop.
- LFSR: Fibonacci, left shift. fb = l[31]^l[21]^l[1]^l[0]; l <= {l[30:0], fb}.
  - On accept: l <= (seed_i==0) ? 32'h1 : seed_i.
  - Advances once per NEXT cycle.
- FSM states: IDLE, ARB_RST, LAUNCH, SAMPLE, NEXT, DONE.
  - IDLE: arb_rst_o=1, launch_o=0. If start_i=1, capture seed, clear resp_o/unstable_o and counters, go to ARB_RST.
  - ARB_RST: RESET_CYC cycles; arb_rst_o=1, launch_o=0. Then go to LAUNCH.
  - LAUNCH: SETTLE cycles; arb_rst_o=0, launch_o=1.
  - SAMPLE: 1 cycle; launch_o=1. ones += arb_s; vote++. If vote == VOTES go to NEXT, else go to ARB_RST.
  - NEXT: 1 cycle; arb_rst_o=1, launch_o=0.
    - resp_o[bit] <= (ones > VOTES/2); unstable_o[bit] <= (ones != 0 && ones != VOTES).
    - Clear ones and vote; bit++; advance LFSR.
    - If bit == RESP_BITS-1, go to DONE; else go to ARB_RST.
  - DONE: resp_valid_o=1 and arb_rst_o=1. On resp_ready_i=1, clear resp_valid_o and go to IDLE. resp_o and unstable_o stay stable in DONE and keep their values in IDLE until the next accept.
- Latency: cycles from the accept edge to resp_valid_o=1 are RESP_BITS*(VOTES*(RESET_CYC+SETTLE+1)+1) + 1.
- chal_o is combinational from lfsr and is constant for all votes of one bit.
- start_i outside IDLE is ignored and not queued. resp_ready_i outside DONE is ignored.
- rst mid-operation aborts immediately to reset values; no partial response is flagged valid.
- Counter widths: vote and ones are clog2(VOTES+1); bit is clog2(RESP_BITS+1); phase counter is clog2(max(RESET_CYC,SETTLE)+1).

Decomposition:
- Package puf_pkg:
  - FSM state enum.
  - LFSR_W=32 and tap constants.
  - Function lfsr_next.
  - Function clog2 helper.
- Sub-module puf_sync2: 2-flop synchroniser with async reset.
- The delay chain (puf_arbiter_chain, STAGES-parametrised, location-constrained) is instantiated beside this block at top level, never inside it, so benches can drive arb_i directly.

Test Plan:
- Defaults, arb_i=1 constant, seed 32'hDEADBEEF, start pulse -> resp_valid_o rises exactly 737 cycles after the accept edge; resp_o=16'hFFFF, unstable_o=0.
- arb_i=0 constant -> resp_o=0, unstable_o=0; busy_o=1 throughout, 0 in DONE.
- Bench drives arb_i per vote as 1,1,0,1,0 for bit 0, then 1 constantly -> resp_o[0]=1, unstable_o[0]=1, unstable_o[15:1]=0.
- seed_i=0 -> chal_o during bit 0 is 32'h1 replicated (64'h00000001_00000001); during bit 1 it is 64'h00000003_00000003.
- start_i held high throughout and resp_ready_i=0 for 20 cycles in DONE -> no re-launch while busy; resp_valid_o and resp_o stay stable; one ready pulse returns to IDLE, and the still-high start_i is then accepted.
- rst asserted in LAUNCH of bit 7 -> same cycle: launch_o=0, arb_rst_o=1, busy_o=0, resp_o=0, resp_valid_o=0; the next start completes normally.
